biquad_seq: RTL

- Sample-rate sequencer for one biquad section, computed with a single time-shared multiplier and accumulator.
- Accepts one input sample per request and steps through the five coefficient products in five cycles.
- Returns a saturated output sample and keeps the x/y history.
- Takes live coefficients from the Wishbone coefficient register file and copies them into shadow registers only between samples, so software writes never corrupt an in-flight computation.

---
 rtl/biquad_pkg.sv | 27 ++
 rtl/biquad_mac.sv | 56 +++++
 rtl/biquad_seq.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/biquad_pkg.sv
// Shared types and constants for the time-shared biquad sequencer.
// Holds the FSM encoding, the tap order and the output clamp bounds.
package biquad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    localparam int NTAPS = 5;

    localparam logic [2:0] TAP_B10 = 3'd0;
    localparam logic [2:0] TAP_B11 = 3'd1;
    localparam logic [2:0] TAP_B12 = 3'd2;
    localparam logic [2:0] TAP_A11 = 3'd3;
    localparam logic [2:0] TAP_A12 = 3'd4;

    function automatic longint sat_hi(input int w);
        return (longint'(1) << (w - 1)) - 1;
    endfunction

    function automatic longint sat_lo(input int w);
        return -(longint'(1) << (w - 1));
    endfunction

endpackage

// File: rtl/biquad_mac.sv
// Single signed multiplier with negate/accumulate and a
// shift-and-clamp output stage back to sample width.
module biquad_mac
    import biquad_pkg::*;
#(
    parameter int DW = 12,
    parameter int CW = 16,
    parameter int AW = DW + CW + 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 neg,
    input  logic signed [CW-1:0] coef,
    input  logic signed [DW-1:0] data,
    output logic signed [DW-1:0] y
);

    localparam int PW = DW + CW;
    localparam logic signed [AW-1:0] HI = AW'(sat_hi(DW));
    localparam logic signed [AW-1:0] LO = AW'(sat_lo(DW));

    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] ext;
    logic signed [AW-1:0] term;
    logic signed [AW-1:0] acc_q;
    logic signed [AW-1:0] shifted;

    assign prod = coef * data;
    assign ext  = {{(AW - PW){prod[PW-1]}}, prod};
    assign term = neg ? -ext : ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_q + term;
        end
    end

    // Arithmetic shift drops the fraction, so rounding is toward -inf.
    assign shifted = acc_q >>> (CW - 1);

    always_comb begin
        y = shifted[DW-1:0];
        if (shifted > HI) begin
            y = HI[DW-1:0];
        end else if (shifted < LO) begin
            y = LO[DW-1:0];
        end
    end

endmodule

// File: rtl/biquad_seq.sv
// Biquad sample sequencer: one product per cycle over five taps,
// with shadowed coefficients reloaded only while idle.
module biquad_seq
    import biquad_pkg::*;
#(
    parameter int DATAWIDTH = 12,
    parameter int COEFWIDTH = 16,
    parameter int ACCWIDTH  = DATAWIDTH + COEFWIDTH + 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic                 sample_valid_i,
    input  logic [DATAWIDTH-1:0] x_i,
    input  logic                 coef_upd_i,
    input  logic [31:0]          a11_i,
    input  logic [31:0]          a12_i,
    input  logic [31:0]          b10_i,
    input  logic [31:0]          b11_i,
    input  logic [31:0]          b12_i,
    output logic [DATAWIDTH-1:0] y_o,
    output logic                 y_valid_o,
    output logic                 busy_o,
    output logic                 overrun_o
);

    localparam int DW = DATAWIDTH;
    localparam int CW = COEFWIDTH;

    state_t state_q;
    state_t state_d;

    logic [2:0] tap_q;
    logic pending_q;
    logic overrun_q;

    logic signed [DW-1:0] x_cur;
    logic signed [DW-1:0] x1;
    logic signed [DW-1:0] x2;
    logic signed [DW-1:0] y1;
    logic signed [DW-1:0] y2;
    logic signed [DW-1:0] y_reg;
    logic signed [DW-1:0] y_sat;

    logic signed [CW-1:0] b10_s;
    logic signed [CW-1:0] b11_s;
    logic signed [CW-1:0] b12_s;
    logic signed [CW-1:0] a11_s;
    logic signed [CW-1:0] a12_s;

    logic signed [CW-1:0] op_c;
    logic signed [DW-1:0] op_d;
    logic op_neg;

    logic accept;
    logic out_fire;
    logic mac_clr;
    logic mac_en;
    logic unused_hi;

    assign unused_hi = ^{a11_i[31:16], a12_i[31:16], b10_i[31:16],
                         b11_i[31:16], b12_i[31:16]};

    assign accept   = (state_q == IDLE) && sample_valid_i && !clr_i;
    assign out_fire = (state_q == OUT) && !clr_i;
    assign mac_clr  = clr_i || accept;
    assign mac_en   = (state_q == MAC) && !clr_i;

    assign y_valid_o = out_fire;
    assign y_o       = out_fire ? y_sat : y_reg;
    assign busy_o    = (state_q != IDLE);
    assign overrun_o = overrun_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (sample_valid_i) state_d = MAC;
                MAC:  if (tap_q == 3'(NTAPS - 1)) state_d = OUT;
                OUT:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Feedback taps are subtracted inside the MAC.
    always_comb begin
        op_c   = b10_s;
        op_d   = x_cur;
        op_neg = 1'b0;
        unique case (tap_q)
            TAP_B10: begin op_c = b10_s; op_d = x_cur; end
            TAP_B11: begin op_c = b11_s; op_d = x1;    end
            TAP_B12: begin op_c = b12_s; op_d = x2;    end
            TAP_A11: begin op_c = a11_s; op_d = y1; op_neg = 1'b1; end
            TAP_A12: begin op_c = a12_s; op_d = y2; op_neg = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tap_q     <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            x_cur     <= '0;
            x1        <= '0;
            x2        <= '0;
            y1        <= '0;
            y2        <= '0;
            y_reg     <= '0;
            b10_s     <= '0;
            b11_s     <= '0;
            b12_s     <= '0;
            a11_s     <= '0;
            a12_s     <= '0;
        end else if (clr_i) begin
            tap_q     <= '0;
            pending_q <= pending_q | coef_upd_i;
            overrun_q <= 1'b0;
            x_cur     <= '0;
            x1        <= '0;
            x2        <= '0;
            y1        <= '0;
            y2        <= '0;
        end else begin
            if (state_q == IDLE && pending_q) begin
                b10_s     <= b10_i[15 -: CW];
                b11_s     <= b11_i[15 -: CW];
                b12_s     <= b12_i[15 -: CW];
                a11_s     <= a11_i[15 -: CW];
                a12_s     <= a12_i[15 -: CW];
                pending_q <= coef_upd_i;
            end else if (coef_upd_i) begin
                pending_q <= 1'b1;
            end
            if (sample_valid_i && state_q != IDLE) begin
                overrun_q <= 1'b1;
            end
            if (accept) begin
                x_cur <= $signed(x_i);
                tap_q <= '0;
            end
            if (state_q == MAC) begin
                tap_q <= tap_q + 3'd1;
            end
            if (state_q == OUT) begin
                x2    <= x1;
                x1    <= x_cur;
                y2    <= y1;
                y1    <= y_sat;
                y_reg <= y_sat;
            end
        end
    end

    biquad_mac #(
        .DW(DW),
        .CW(CW),
        .AW(ACCWIDTH)
    ) u_mac (
        .clk  (clk_i),
        .rst_n(rst_ni),
        .clr  (mac_clr),
        .en   (mac_en),
        .neg  (op_neg),
        .coef (op_c),
        .data (op_d),
        .y    (y_sat)
    );

endmodule
